mem_io_resp: RTL

Responder end of the CPU's byte-serial memory bus: services one byte access per cycle from the memory controller, backing a byte-addressed RAM and a small memory-mapped IO window. Returns read data one cycle after the address, accepts stores at the clock edge, and buffers console output in a TX FIFO. Asserts `io_buffer_full` to stall the controller, which re-presents the same access until the stall drops. Sits between the CPU's memory controller and the board UART/console, replacing the bare RAM macro.

---
 rtl/mem_io_resp_pkg.sv | 22 ++
 rtl/mem_io_resp_byte_fifo.sv | 49 ++++
 rtl/mem_io_resp.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_io_resp_pkg.sv
// Shared constants and helpers for the byte-serial memory responder.
package mem_io_resp_pkg;

  // IO window base; bits [17:16] of an address select it.
  localparam logic [31:0] IO_BASE     = 32'h0003_0000;
  localparam logic [1:0]  IO_SEL_BITS = IO_BASE[17:16];

  // IO register offsets, selected by mem_a[2:0].
  typedef enum logic [2:0] {
    IO_DATA = 3'd0,
    IO_STAT = 3'd4
  } io_reg_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // True when the two decode bits of an address land in the IO window.
  function automatic logic is_io(input logic [1:0] sel_bits);
    return sel_bits == IO_SEL_BITS;
  endfunction

endpackage

// File: rtl/mem_io_resp_byte_fifo.sv
// Byte-wide FIFO with power-of-two depth; caller guarantees no overflow/underflow.
module mem_io_resp_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/mem_io_resp.sv
// Responder for the CPU byte-serial memory bus: byte RAM plus a small IO window
// with console TX FIFO, RX holding register and a sticky halt flag.
module mem_io_resp
  import mem_io_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int unsigned CW        = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RAM_BYTES = 2 ** ADDR_WIDTH;

  logic                  acc;
  logic                  io_sel;
  logic                  ram_we;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  rx_pop;
  logic                  halt_set;
  logic [7:0]            io_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [CW-1:0]         tx_count;
  logic [CW-1:0]         tx_count_nxt;
  logic                  tx_empty;
  logic                  rx_full;
  logic [7:0]            rx_byte;
  logic [7:0]            ram [RAM_BYTES];

  // Address bits above the decode field carry no meaning here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:18];

  assign ram_addr = mem_a[ADDR_WIDTH-1:0];

  // Access qualification, address decode and IO read mux.
  always_comb begin
    acc      = rdy && !io_buffer_full;
    io_sel   = is_io(mem_a[17:16]);
    ram_we   = FALSE;
    tx_push  = FALSE;
    rx_pop   = FALSE;
    halt_set = FALSE;
    io_rdata = 8'h00;

    case (mem_a[2:0])
      IO_DATA: io_rdata = rx_full ? rx_byte : 8'h00;
      IO_STAT: io_rdata = {6'b0, rx_full, io_buffer_full};
      default: io_rdata = 8'h00;
    endcase

    if (acc && io_sel) begin
      case (mem_a[2:0])
        IO_DATA: begin
          tx_push = mem_wr;
          rx_pop  = !mem_wr;
        end
        IO_STAT: halt_set = mem_wr;
        default: ;
      endcase
    end else if (acc) begin
      ram_we = mem_wr;
    end
  end

  // Console pop and the occupancy the FIFO will hold after this edge.
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign rx_ready     = !rx_full;

  mem_io_resp_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (mem_wdata),
    .dout  (tx_data),
    .count (tx_count),
    .empty (tx_empty)
  );

  // RAM store port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= mem_wdata;
    end
  end

  // Load data register, read-first against a same-cycle store; held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 8'h00;
    end else if (acc && !mem_wr) begin
      mem_rdata <= io_sel ? io_rdata : ram[ram_addr];
    end
  end

  // Stall before the last free slot so a retried store can never overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_buffer_full <= FALSE;
    end else begin
      io_buffer_full <= (tx_count_nxt >= CW'(TX_DEPTH - 1));
    end
  end

  // RX holding register; capture only when empty, so a pop never races a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= FALSE;
      rx_byte <= 8'h00;
    end else if (rx_valid && rx_ready) begin
      rx_full <= TRUE;
      rx_byte <= rx_data;
    end else if (rx_pop) begin
      rx_full <= FALSE;
    end
  end

  // Sticky halt request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sim_halt <= FALSE;
    end else if (halt_set) begin
      sim_halt <= TRUE;
    end
  end

endmodule
